// File: rtl/mem_req_pkg.sv
// Shared types for the memory request scheduler: FSM state encoding and queued request layout.
package mem_req_pkg;

  // Field widths are the widest ADDR_W/DATA_W the scheduler supports.
  localparam int unsigned REQ_ADDR_W = 10;
  localparam int unsigned REQ_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with wrapping pointers and an occupancy count; head is read combinationally.
module mem_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_scheduler.sv
// Queues client read/write requests and issues them one at a time to a memory controller.
// Optional issue counters (rd_issued/wr_issued) are built when MEM_REQ_STATS_EN is defined.
module mem_req_scheduler
  import mem_req_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_W-1:0]      resp_data,
  output logic                   mc_read,
  output logic                   mc_write,
  output logic [ADDR_W-1:0]      mc_address,
  output logic [DATA_W-1:0]      mc_memory_val,
  input  logic [DATA_W-1:0]      mc_value,
  output logic [$clog2(DEPTH):0] queue_count
`ifdef MEM_REQ_STATS_EN
  ,
  output logic [15:0]            rd_issued,
  output logic [15:0]            wr_issued
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  state_t      state, state_nxt;
  req_entry_t  push_entry;
  req_entry_t  head;
  logic        push, pop, full, empty, issue;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(req_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (queue_count)
  );

  always_comb begin
    pop              = (state == ISSUE);
    req_ready        = !full || pop;
    push             = req_valid && req_ready;
    push_entry.write = req_write;
    push_entry.addr  = REQ_ADDR_W'(req_addr);
    push_entry.wdata = REQ_DATA_W'(req_wdata);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!empty) state_nxt = ISSUE;
      // A push landing this cycle keeps the write stream going without an IDLE bubble.
      ISSUE:   if (head.write) state_nxt = (queue_count > CW'(1) || push) ? ISSUE : IDLE;
               else            state_nxt = WAIT_RD;
      WAIT_RD: state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = empty ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue         = (state == ISSUE) && !rst;
    mc_write      = issue && head.write;
    mc_read       = issue && !head.write;
    mc_address    = issue ? head.addr[ADDR_W-1:0]  : addr_q;
    mc_memory_val = issue ? head.wdata[DATA_W-1:0] : wdata_q;
    resp_valid    = (state == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        addr_q  <= head.addr[ADDR_W-1:0];
        wdata_q <= head.wdata[DATA_W-1:0];
      end
      if (state == WAIT_RD) resp_data <= mc_value;
    end
  end

`ifdef MEM_REQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_issued <= '0;
      wr_issued <= '0;
    end else begin
      if (mc_read  && rd_issued != '1) rd_issued <= rd_issued + 16'd1;
      if (mc_write && wr_issued != '1) wr_issued <= wr_issued + 16'd1;
    end
  end
`endif

endmodule
